// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Two-requester, round-robin arbiter in front of a single-byte I2C master.
//   A winning requester's command is latched onto the master command
//   fields. The arbiter issues one START+STOP strobe and then waits for the
//   master to finish. If the master does not finish within TIMEOUT cycles,
//   the transaction is aborted. In either case the granted requester gets
//   a one-cycle done pulse together with its rdata, nack and tout results.
//
// Parameters
//   TIMEOUT    maximum WAIT-state cycles before abort (1..1023)
// Ports
//   clk        single clock, rising edge
//   reset      synchronous reset, active-low
//   req[1:0]   per-requester request, held until done[i]
//   rd_wr0/1   requester direction (1 = read)
//   addr0/1    requester 7-bit slave address
//   wdata0/1   requester write byte
//   gnt[1:0]   one-hot grant, START through DONE
//   done[1:0]  one-cycle completion pulse to the granted requester
//   rdata      read byte, valid with done
//   nack       slave NACK flag, valid with done
//   tout       timeout flag, valid with done
//   m_start    master start strobe
//   m_stop     master stop strobe
//   m_rd_wr    latched master direction
//   m_address  latched master address
//   m_din      latched master write byte
//   m_done     master end-of-transaction pulse
//   m_ack      master ack result (1 = ACK), qualified by m_done
//   m_dout     master read data, qualified by m_done
module i2c_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       rd_wr0,
    input  logic       rd_wr1,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [7:0] rdata,
    output logic       nack,
    output logic       tout,
    output logic       m_start,
    output logic       m_stop,
    output logic       m_rd_wr,
    output logic [6:0] m_address,
    output logic [7:0] m_din,
    input  logic       m_done,
    input  logic       m_ack,
    input  logic [7:0] m_dout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [9:0] TIMEOUT_W = 10'(TIMEOUT);

    logic [1:0] state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       win_q, win_d;
    logic [9:0] cnt_q, cnt_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic [7:0] rdata_q, rdata_d;
    logic       nack_q, nack_d;
    logic       tout_q, tout_d;
    logic       m_start_q, m_start_d;
    logic       m_stop_q, m_stop_d;
    logic       m_rd_wr_q, m_rd_wr_d;
    logic [6:0] m_address_q, m_address_d;
    logic [7:0] m_din_q, m_din_d;

    logic       sel;
    logic [9:0] cnt_inc;

    // A lone requester wins outright; on a tie the pointer decides.
    always_comb begin
        sel = 1'b0;
        unique case (req)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ptr_q;
            default: sel = 1'b0;
        endcase
    end

    assign cnt_inc = cnt_q + 10'd1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        rdata_d     = rdata_q;
        nack_d      = nack_q;
        tout_d      = tout_q;
        m_start_d   = 1'b0;
        m_stop_d    = 1'b0;
        m_rd_wr_d   = m_rd_wr_q;
        m_address_d = m_address_q;
        m_din_d     = m_din_q;

        // Outputs are registered, so strobes and pulses are set on the
        // transition into the state in which they must be visible.
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    win_d       = sel;
                    gnt_d       = sel ? 2'b10 : 2'b01;
                    m_rd_wr_d   = sel ? rd_wr1 : rd_wr0;
                    m_address_d = sel ? addr1  : addr0;
                    m_din_d     = sel ? wdata1 : wdata0;
                    m_start_d   = 1'b1;
                    m_stop_d    = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                // m_done beats a simultaneous timeout.
                if (m_done) begin
                    rdata_d = m_dout;
                    nack_d  = ~m_ack;
                    tout_d  = 1'b0;
                    done_d  = gnt_q;
                    state_d = DONE;
                end else if (cnt_inc == TIMEOUT_W) begin
                    rdata_d = '0;
                    nack_d  = 1'b1;
                    tout_d  = 1'b1;
                    done_d  = gnt_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = ~win_q;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            win_q       <= 1'b0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            nack_q      <= 1'b0;
            tout_q      <= 1'b0;
            m_start_q   <= 1'b0;
            m_stop_q    <= 1'b0;
            m_rd_wr_q   <= 1'b0;
            m_address_q <= '0;
            m_din_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            nack_q      <= nack_d;
            tout_q      <= tout_d;
            m_start_q   <= m_start_d;
            m_stop_q    <= m_stop_d;
            m_rd_wr_q   <= m_rd_wr_d;
            m_address_q <= m_address_d;
            m_din_q     <= m_din_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign nack      = nack_q;
    assign tout      = tout_q;
    assign m_start   = m_start_q;
    assign m_stop    = m_stop_q;
    assign m_rd_wr   = m_rd_wr_q;
    assign m_address = m_address_q;
    assign m_din     = m_din_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter
//   Table-driven bench for i2c_arbiter built with TIMEOUT = 8. Each table row
//   holds the inputs for one clock cycle and the outputs expected just after
//   that edge. Hand-written sequences then cover the timeout race, the plain
//   timeout and round-robin contention from reset.
module tb_i2c_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic       rd_wr0, rd_wr1;
    logic [6:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic [1:0] gnt, done;
    logic [7:0] rdata;
    logic       nack, tout, m_start, m_stop, m_rd_wr;
    logic [6:0] m_address;
    logic [7:0] m_din;
    logic       m_done, m_ack;
    logic [7:0] m_dout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    i2c_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req),
        .rd_wr0(rd_wr0), .rd_wr1(rd_wr1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .rdata(rdata), .nack(nack), .tout(tout),
        .m_start(m_start), .m_stop(m_stop), .m_rd_wr(m_rd_wr),
        .m_address(m_address), .m_din(m_din),
        .m_done(m_done), .m_ack(m_ack), .m_dout(m_dout)
    );

    typedef struct {
        logic       rst_n;
        logic [1:0] req;
        logic       rw0, rw1;
        logic [6:0] a0, a1;
        logic [7:0] w0, w1;
        logic       md, mack;
        logic [7:0] mdout;
        logic [1:0] e_gnt, e_done;
        logic [7:0] e_rdata;
        logic       e_nack, e_tout, e_start, e_stop, e_rw;
        logic [6:0] e_addr;
        logic [7:0] e_din;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [1:0] exp_g;

        //           rst req  rw0  rw1  a0     a1     w0     w1     md   mack mdout | gnt   done  rdata  nk   to   st   sp   rw   addr   din
        tbl[0]  = '{1'b0,2'b00,1'b0,1'b0,7'h50,7'h2A,8'hA5,8'h5A,1'b0,1'b0,8'h00, 2'b00,2'b00,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,7'h00,8'h00};
        tbl[1]  = '{1'b1,2'b01,1'b0,1'b1,7'h50,7'h2A,8'hA5,8'h5A,1'b0,1'b0,8'h00, 2'b01,2'b00,8'h00,1'b0,1'b0,1'b1,1'b1,1'b0,7'h50,8'hA5};
        tbl[2]  = '{1'b1,2'b01,1'b0,1'b1,7'h11,7'h2A,8'hFF,8'h5A,1'b0,1'b0,8'h00, 2'b01,2'b00,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,7'h50,8'hA5};
        tbl[3]  = '{1'b1,2'b01,1'b0,1'b1,7'h11,7'h2A,8'hFF,8'h5A,1'b1,1'b1,8'h77, 2'b01,2'b01,8'h77,1'b0,1'b0,1'b0,1'b0,1'b0,7'h50,8'hA5};
        tbl[4]  = '{1'b1,2'b00,1'b0,1'b1,7'h11,7'h2A,8'hFF,8'h5A,1'b0,1'b0,8'h00, 2'b00,2'b00,8'h77,1'b0,1'b0,1'b0,1'b0,1'b0,7'h50,8'hA5};
        tbl[5]  = '{1'b1,2'b10,1'b0,1'b1,7'h11,7'h2A,8'hFF,8'h5A,1'b1,1'b1,8'h99, 2'b10,2'b00,8'h77,1'b0,1'b0,1'b1,1'b1,1'b1,7'h2A,8'h5A};
        tbl[6]  = '{1'b1,2'b10,1'b0,1'b1,7'h11,7'h2A,8'hFF,8'h5A,1'b0,1'b0,8'h00, 2'b10,2'b00,8'h77,1'b0,1'b0,1'b0,1'b0,1'b1,7'h2A,8'h5A};
        tbl[7]  = '{1'b1,2'b10,1'b0,1'b1,7'h11,7'h2A,8'hFF,8'h5A,1'b0,1'b0,8'h00, 2'b10,2'b00,8'h77,1'b0,1'b0,1'b0,1'b0,1'b1,7'h2A,8'h5A};
        tbl[8]  = '{1'b1,2'b10,1'b0,1'b1,7'h11,7'h2A,8'hFF,8'h5A,1'b1,1'b1,8'h3C, 2'b10,2'b10,8'h3C,1'b0,1'b0,1'b0,1'b0,1'b1,7'h2A,8'h5A};
        tbl[9]  = '{1'b1,2'b00,1'b0,1'b1,7'h11,7'h2A,8'hFF,8'h5A,1'b0,1'b0,8'h00, 2'b00,2'b00,8'h3C,1'b0,1'b0,1'b0,1'b0,1'b1,7'h2A,8'h5A};
        tbl[10] = '{1'b1,2'b11,1'b0,1'b1,7'h12,7'h2A,8'h34,8'h5A,1'b0,1'b0,8'h00, 2'b01,2'b00,8'h3C,1'b0,1'b0,1'b1,1'b1,1'b0,7'h12,8'h34};
        tbl[11] = '{1'b1,2'b11,1'b0,1'b1,7'h12,7'h2A,8'h34,8'h5A,1'b0,1'b0,8'h00, 2'b01,2'b00,8'h3C,1'b0,1'b0,1'b0,1'b0,1'b0,7'h12,8'h34};
        tbl[12] = '{1'b1,2'b11,1'b0,1'b1,7'h12,7'h2A,8'h34,8'h5A,1'b1,1'b0,8'hC3, 2'b01,2'b01,8'hC3,1'b1,1'b0,1'b0,1'b0,1'b0,7'h12,8'h34};
        tbl[13] = '{1'b1,2'b11,1'b0,1'b1,7'h12,7'h2A,8'h34,8'h5A,1'b0,1'b0,8'h00, 2'b00,2'b00,8'hC3,1'b1,1'b0,1'b0,1'b0,1'b0,7'h12,8'h34};
        tbl[14] = '{1'b1,2'b11,1'b0,1'b1,7'h12,7'h2A,8'h34,8'h5A,1'b0,1'b0,8'h00, 2'b10,2'b00,8'hC3,1'b1,1'b0,1'b1,1'b1,1'b1,7'h2A,8'h5A};
        tbl[15] = '{1'b1,2'b11,1'b0,1'b1,7'h12,7'h2A,8'h34,8'h5A,1'b0,1'b0,8'h00, 2'b10,2'b00,8'hC3,1'b1,1'b0,1'b0,1'b0,1'b1,7'h2A,8'h5A};
        tbl[16] = '{1'b0,2'b11,1'b0,1'b1,7'h12,7'h2A,8'h34,8'h5A,1'b1,1'b1,8'hEE, 2'b00,2'b00,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,7'h00,8'h00};
        tbl[17] = '{1'b1,2'b11,1'b0,1'b1,7'h12,7'h2A,8'h34,8'h5A,1'b0,1'b0,8'h00, 2'b01,2'b00,8'h00,1'b0,1'b0,1'b1,1'b1,1'b0,7'h12,8'h34};

        for (int i = 0; i < 18; i++) begin
            reset  = tbl[i].rst_n;
            req    = tbl[i].req;
            rd_wr0 = tbl[i].rw0;
            rd_wr1 = tbl[i].rw1;
            addr0  = tbl[i].a0;
            addr1  = tbl[i].a1;
            wdata0 = tbl[i].w0;
            wdata1 = tbl[i].w1;
            m_done = tbl[i].md;
            m_ack  = tbl[i].mack;
            m_dout = tbl[i].mdout;
            tick();
            check($sformatf("row%0d gnt", i),     32'(gnt),       32'(tbl[i].e_gnt));
            check($sformatf("row%0d done", i),    32'(done),      32'(tbl[i].e_done));
            check($sformatf("row%0d rdata", i),   32'(rdata),     32'(tbl[i].e_rdata));
            check($sformatf("row%0d nack", i),    32'(nack),      32'(tbl[i].e_nack));
            check($sformatf("row%0d tout", i),    32'(tout),      32'(tbl[i].e_tout));
            check($sformatf("row%0d m_start", i), 32'(m_start),   32'(tbl[i].e_start));
            check($sformatf("row%0d m_stop", i),  32'(m_stop),    32'(tbl[i].e_stop));
            check($sformatf("row%0d m_rd_wr", i), 32'(m_rd_wr),   32'(tbl[i].e_rw));
            check($sformatf("row%0d m_addr", i),  32'(m_address), 32'(tbl[i].e_addr));
            check($sformatf("row%0d m_din", i),   32'(m_din),     32'(tbl[i].e_din));
        end

        // Race: m_done in the 8th WAIT cycle, when the counter reaches TIMEOUT.
        m_done = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("race no early done", 32'(done), 32'(2'b00));
        check("race gnt held", 32'(gnt), 32'(2'b01));
        m_done = 1'b1; m_ack = 1'b1; m_dout = 8'hA6;
        tick();
        m_done = 1'b0;
        check("race done", 32'(done), 32'(2'b01));
        check("race tout", 32'(tout), 32'(1'b0));
        check("race nack", 32'(nack), 32'(1'b0));
        check("race rdata", 32'(rdata), 32'(8'hA6));

        // Plain timeout on requester 1.
        tick();
        tick();
        check("to gnt", 32'(gnt), 32'(2'b10));
        check("to m_start", 32'(m_start), 32'(1'b1));
        n = 0;
        while (done == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check("to cycles to done", 32'(n), 32'd9);
        check("to done", 32'(done), 32'(2'b10));
        check("to tout", 32'(tout), 32'(1'b1));
        check("to nack", 32'(nack), 32'(1'b1));
        check("to rdata", 32'(rdata), 32'(8'h00));
        tick();
        check("to done one cycle", 32'(done), 32'(2'b00));
        check("to gnt cleared", 32'(gnt), 32'(2'b00));
        check("to rdata hold", 32'(rdata), 32'(8'h00));

        // Contention from reset: grants alternate 0,1,0,1.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            while (m_start !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            check($sformatf("rr%0d start seen", t), 32'(m_start), 32'(1'b1));
            check($sformatf("rr%0d gnt", t), 32'(gnt), 32'(exp_g));
            tick();
            m_done = 1'b1; m_ack = 1'b1; m_dout = 8'(t);
            tick();
            m_done = 1'b0;
            check($sformatf("rr%0d done", t), 32'(done), 32'(exp_g));
            check($sformatf("rr%0d rdata", t), 32'(rdata), 32'(t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
